// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer: fetches both words of an 8-byte line from the word RAM
// and writes the assembled line in one cycle. Optional critical-word-first via `REFILL_CWF_EN.
module icache_refill_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INDEX_W = 4,
   parameter int unsigned TAG_W   = ADDR_W - INDEX_W - 3,
   parameter int unsigned RD_WAIT = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               miss_req,
   input  logic [ADDR_W-1:0]  miss_addr,
   output logic               busy,
   output logic               mem_rden,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_w_sel,
   input  logic [31:0]        mem_data,
   output logic               line_we,
   output logic [INDEX_W-1:0] line_index,
   output logic [TAG_W-1:0]   line_tag,
   output logic [63:0]        line_data,
`ifdef REFILL_CWF_EN
   output logic               crit_valid,
   output logic [31:0]        crit_data,
`endif
   output logic               refill_done
);

   localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_WAIT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD0   = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_RD1   = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   logic [2:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-4:0] line_addr_q;
   logic [31:0]       word0;
   logic [31:0]       word1;
   logic              first_q;
   logic              first_sel;
   logic              unused_addr_bits;

`ifdef REFILL_CWF_EN
   assign first_sel = miss_addr[2];
`else
   assign first_sel = 1'b0;
`endif
   assign unused_addr_bits = ^miss_addr[2:0];

   assign mem_addr   = {line_addr_q, 3'b000};
   assign line_index = line_addr_q[INDEX_W-1:0];
   assign line_tag   = line_addr_q[ADDR_W-4:INDEX_W];
   assign line_data  = {word1, word0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         line_addr_q <= '0;
         word0       <= '0;
         word1       <= '0;
         first_q     <= 1'b0;
         busy        <= 1'b0;
         mem_rden    <= 1'b0;
         mem_w_sel   <= 1'b0;
         line_we     <= 1'b0;
         refill_done <= 1'b0;
`ifdef REFILL_CWF_EN
         crit_valid  <= 1'b0;
         crit_data   <= '0;
`endif
      end else begin
         line_we     <= 1'b0;
         refill_done <= 1'b0;
`ifdef REFILL_CWF_EN
         crit_valid  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (miss_req) begin
                  line_addr_q <= miss_addr[ADDR_W-1:3];
                  first_q     <= first_sel;
                  busy        <= 1'b1;
                  mem_rden    <= 1'b1;
                  mem_w_sel   <= first_sel;
                  cnt         <= CNT_LOAD;
                  state       <= S_RD0;
               end
            end
            S_RD0: begin
               if (cnt == '0) begin
                  if (first_q) word1 <= mem_data;
                  else         word0 <= mem_data;
`ifdef REFILL_CWF_EN
                  crit_valid <= 1'b1;
                  crit_data  <= mem_data;
`endif
                  // rden and w_sel flip on the same edge so the select never moves mid-read
                  mem_rden  <= 1'b0;
                  mem_w_sel <= ~first_q;
                  state     <= S_GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_GAP: begin
               mem_rden <= 1'b1;
               cnt      <= CNT_LOAD;
               state    <= S_RD1;
            end
            S_RD1: begin
               if (cnt == '0) begin
                  if (first_q) word0 <= mem_data;
                  else         word1 <= mem_data;
                  mem_rden    <= 1'b0;
                  line_we     <= 1'b1;
                  refill_done <= 1'b1;
                  state       <= S_WRITE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_WRITE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
